// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch front end.
package fetch_pkg;

    localparam int unsigned INST_BYTES = 4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_if.sv
// Memory and decode-side signal bundle of the fetch unit.
// o_misalign exists only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_if;

    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        o_misalign;

    modport master (
        output o_mem_req, o_mem_addr, o_inst_valid, o_inst, o_inst_pc, o_misalign,
        input  i_mem_ack, i_mem_rdata, i_inst_ready, i_redirect, i_redirect_pc
    );
    modport slave (
        input  o_mem_req, o_mem_addr, o_inst_valid, o_inst, o_inst_pc, o_misalign,
        output i_mem_ack, i_mem_rdata, i_inst_ready, i_redirect, i_redirect_pc
    );
`else
    modport master (
        output o_mem_req, o_mem_addr, o_inst_valid, o_inst, o_inst_pc,
        input  i_mem_ack, i_mem_rdata, i_inst_ready, i_redirect, i_redirect_pc
    );
    modport slave (
        input  o_mem_req, o_mem_addr, o_inst_valid, o_inst, o_inst_pc,
        output i_mem_ack, i_mem_rdata, i_inst_ready, i_redirect, i_redirect_pc
    );
`endif

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, inst} entries; flush wins over push, head reads as zero when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  entry_t                   push_entry_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     head_valid_o,
    output entry_t                   head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0) && !flush_i;
    assign do_push = push_i && !flush_i && ((count_q != FULL) || do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is data only; occupancy tracking alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_o       = head_valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// RV32 fetch front end: PC sequencing, single-outstanding memory reads, prefetch queue, redirects.
// Optional misaligned-redirect trap and HALT state under FETCH_ALIGN_CHECK_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic      i_clk,
    input logic      i_rst_n,
    fetch_if.master  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_FLUSH = FLUSH;
    localparam logic [1:0] S_HALT  = HALT;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic          misalign_q, misalign_d;
    logic [CW-1:0] count;
    logic          head_valid;
    entry_t        head, push_entry;
    logic          issue, mem_req, ack, push, pop;
    logic [31:0]   target;
    logic          tgt_bad;
    logic [1:0]    resume_st;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target     = bus.i_redirect_pc;
    assign tgt_bad    = |bus.i_redirect_pc[1:0];
    assign resume_st  = misalign_q ? S_HALT : S_RUN;
    assign bus.o_misalign = misalign_q;
`else
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^bus.i_redirect_pc[1:0];
    assign target     = {bus.i_redirect_pc[31:2], 2'b00};
    assign tgt_bad    = 1'b0;
    assign resume_st  = S_RUN;
`endif

    // A new read starts only with no read in flight, so count < DEPTH guarantees room for its ack.
    assign issue   = i_rst_n && (state_q == S_RUN) && !req_q && !bus.i_redirect && (count < FULL);
    assign mem_req = i_rst_n && (req_q || issue);
    assign ack     = mem_req && bus.i_mem_ack;
    assign push    = ack && (state_q == S_RUN) && !bus.i_redirect;
    assign pop     = head_valid && bus.i_inst_ready;

    assign push_entry = '{pc: (req_q ? addr_q : fetch_pc_q), inst: bus.i_mem_rdata};

    assign bus.o_mem_req    = mem_req;
    assign bus.o_mem_addr   = req_q ? addr_q : fetch_pc_q;
    assign bus.o_inst_valid = head_valid;
    assign bus.o_inst       = head.inst;
    assign bus.o_inst_pc    = head.pc;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        misalign_d = misalign_q;

        if (ack) begin
            req_d = 1'b0;
        end else if (issue) begin
            req_d  = 1'b1;
            addr_d = fetch_pc_q;
        end

        if (push) fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);

        if ((state_q == S_FLUSH) && ack) state_d = resume_st;

        // Redirect overrides everything; a still-pending stale read must drain through FLUSH.
        if (bus.i_redirect) begin
            fetch_pc_d = target;
            misalign_d = tgt_bad;
            if (req_q && !ack)  state_d = S_FLUSH;
            else if (tgt_bad)   state_d = S_HALT;
            else                state_d = S_RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_RUN;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge i_clk) begin
        addr_q <= addr_d;
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk_i        (i_clk),
        .rst_ni       (i_rst_n),
        .flush_i      (bus.i_redirect),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .count_o      (count),
        .head_valid_o (head_valid),
        .head_o       (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected memory addresses and decode entries are queued by
// the stimulus and consumed by a monitor on every memory ack and every decode handshake.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int lat = 0;
    int wait_cnt = 0;
    assign bus.i_mem_ack   = bus.o_mem_req && (wait_cnt >= lat);
    assign bus.i_mem_rdata = bus.o_mem_addr ^ 32'hA5A5_A5A5;
    always @(posedge clk) wait_cnt <= (bus.o_mem_req && !bus.i_mem_ack) ? wait_cnt + 1 : 0;

    logic [31:0] exp_addr[$];
    entry_t      exp_inst[$];
    int checks = 0;
    int errors = 0;
    int acks = 0;
    int pops = 0;
    bit done = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic monitor_step();
        entry_t e;
        if (rst_n && bus.o_mem_req && bus.i_mem_ack) begin
            acks++;
            if (exp_addr.size() == 0) check("mem_addr_unexpected", bus.o_mem_addr, 32'hDEAD_BEEF);
            else check("mem_addr", bus.o_mem_addr, exp_addr.pop_front());
        end
        if (rst_n && bus.o_inst_valid && bus.i_inst_ready && !bus.i_redirect) begin
            pops++;
            if (exp_inst.size() == 0) begin
                check("inst_unexpected", bus.o_inst_pc, 32'hDEAD_BEEF);
            end else begin
                e = exp_inst.pop_front();
                check("inst_pc", bus.o_inst_pc, e.pc);
                check("inst_word", bus.o_inst, e.inst);
            end
        end
    endtask

    task automatic load_stream(logic [31:0] base, int n, bit has_stale, logic [31:0] stale);
        logic [31:0] a;
        exp_addr.delete();
        exp_inst.delete();
        if (has_stale) exp_addr.push_back(stale);
        a = base;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(a);
            exp_inst.push_back('{pc: a, inst: a ^ 32'hA5A5_A5A5});
            a = a + 32'd4;
        end
    endtask

    task automatic redirect(logic [31:0] tgt, int n, bit has_stale, logic [31:0] stale);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = tgt;
        load_stream(tgt, n, has_stale, stale);
        tick();
        bus.i_redirect    = 1'b0;
    endtask

    task automatic quiesce();
        bus.i_inst_ready = 1'b0;
        lat = 0;
        repeat (12) tick();
    endtask

    task automatic wait_pops(int k, string name);
        int base = pops;
        int t = 0;
        while ((pops < base + k) && (t < 100)) begin
            tick();
            t++;
        end
        check(name, 32'(pops - base >= k), 32'd1);
    endtask

    task automatic wait_req(logic [31:0] a, int wc, string name);
        bit hit = 0;
        for (int t = 0; t < 100; t++) begin
            sample();
            if (bus.o_mem_req && (bus.o_mem_addr == a) && (wait_cnt == wc)) begin
                hit = 1;
                break;
            end
            tick();
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic stimulus();
        int base;
        bus.i_inst_ready  = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 32'h0;

        // Reset state
        repeat (2) tick();
        sample();
        check("rst_mem_req", 32'(bus.o_mem_req), 32'd0);
        check("rst_mem_addr", bus.o_mem_addr, 32'h0000_0000);
        check("rst_inst_valid", 32'(bus.o_inst_valid), 32'd0);
        check("rst_inst", bus.o_inst, 32'h0);
        check("rst_inst_pc", bus.o_inst_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_misalign", 32'(bus.o_misalign), 32'd0);
`endif

        // Sustained zero-wait streaming from RESET_PC
        tick();
        load_stream(32'h0, 32, 0, 32'h0);
        bus.i_inst_ready = 1'b1;
        rst_n = 1'b1;
        sample();
        check("first_req", 32'(bus.o_mem_req), 32'd1);
        check("first_addr", bus.o_mem_addr, 32'h0);
        check("first_valid", 32'(bus.o_inst_valid), 32'd0);
        tick();
        sample();
        check("stream_valid_after_ack", 32'(bus.o_inst_valid), 32'd1);
        wait_pops(8, "stream_pops");

        // Full queue stops fetch at exactly DEPTH acks; ready resumes it next cycle
        quiesce();
        redirect(32'h1000, 16, 0, 32'h0);
        base = acks;
        repeat (8) tick();
        sample();
        check("fill_ack_count", 32'(acks - base), 32'd4);
        check("fill_req_idle", 32'(bus.o_mem_req), 32'd0);
        tick();
        bus.i_inst_ready = 1'b1;
        tick();
        sample();
        check("resume_req", 32'(bus.o_mem_req), 32'd1);
        check("resume_addr", bus.o_mem_addr, 32'h1010);
        wait_pops(6, "resume_pops");

        // Redirect while a slow read is in flight: hold it, drop its data
        quiesce();
        lat = 3;
        bus.i_inst_ready = 1'b1;
        redirect(32'h0, 16, 0, 32'h0);
        wait_req(32'h8, 0, "req_at_8");
        tick();
        redirect(32'h100, 16, 1, 32'h8);
        sample();
        check("flush_hold_req", 32'(bus.o_mem_req), 32'd1);
        check("flush_hold_addr", bus.o_mem_addr, 32'h8);

        // Redirect coinciding with an ack
        wait_req(32'h104, 2, "req_at_104");
        tick();
        redirect(32'h40, 16, 1, 32'h104);
        sample();
        check("coincide_next_req", 32'(bus.o_mem_req), 32'd1);
        check("coincide_next_addr", bus.o_mem_addr, 32'h40);
        wait_pops(2, "coincide_pops");

        // PC wrap and 2-cycle redirect-to-decode latency
        quiesce();
        bus.i_inst_ready = 1'b1;
        redirect(32'hFFFF_FFFC, 16, 0, 32'h0);
        sample();
        check("wrap_first_addr", bus.o_mem_addr, 32'hFFFF_FFFC);
        tick();
        sample();
        check("wrap_next_addr", bus.o_mem_addr, 32'h0000_0000);
        check("wrap_target_valid", 32'(bus.o_inst_valid), 32'd1);
        wait_pops(4, "wrap_pops");

`ifdef FETCH_ALIGN_CHECK_EN
        quiesce();
        bus.i_inst_ready = 1'b1;
        redirect(32'h102, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            sample();
            check("halt_misalign", 32'(bus.o_misalign), 32'd1);
            check("halt_no_req", 32'(bus.o_mem_req), 32'd0);
            tick();
        end
        redirect(32'h200, 16, 0, 32'h0);
        sample();
        check("resume_misalign", 32'(bus.o_misalign), 32'd0);
        check("resume_align_addr", bus.o_mem_addr, 32'h200);
        check("resume_align_req", 32'(bus.o_mem_req), 32'd1);
        wait_pops(3, "align_pops");
`endif

        // Reset during an outstanding read drops it at once
        quiesce();
        lat = 3;
        redirect(32'h300, 16, 0, 32'h0);
        tick();
        rst_n = 1'b0;
        sample();
        check("midrst_req", 32'(bus.o_mem_req), 32'd0);
        repeat (2) tick();
        load_stream(32'h0, 16, 0, 32'h0);
        lat = 0;
        bus.i_inst_ready = 1'b1;
        rst_n = 1'b1;
        sample();
        check("rerst_req", 32'(bus.o_mem_req), 32'd1);
        check("rerst_addr", bus.o_mem_addr, 32'h0);
        wait_pops(4, "rerst_pops");
    endtask

    initial begin
        fork
            begin
                while (!done) begin
                    @(negedge clk);
                    monitor_step();
                end
            end
            begin
                stimulus();
                done = 1;
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the RV32 core: keeps the fetch PC, issues word reads to instruction memory, buffers returned words in a small prefetch queue, and presents {instruction, PC} to the decode stage over a valid/ready handshake. It is the producer side of the decoder's 32-bit instruction input. Branch and jump redirects from execute flush the queue and restart fetch at the target.

## Interface
- DEPTH, 4: prefetch queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset; word-aligned.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- o_mem_req  out  1  instruction memory read request.
- o_mem_addr  out  32  read address; word-aligned.
- i_mem_ack  in  1  request completes this cycle; i_mem_rdata is valid.
- i_mem_rdata  in  32  instruction word.
- o_inst_valid  out  1  queue head holds a valid instruction.
- o_inst  out  32  head instruction.
- o_inst_pc  out  32  head PC.
- i_inst_ready  in  1  decode accepts the head this cycle.
- i_redirect  in  1  flush and restart fetch.
- i_redirect_pc  in  32  restart address.
- o_misalign  out  1  misaligned redirect trap; present only with FETCH_ALIGN_CHECK_EN.

## Operation
- Reset values: o_mem_req 0, o_mem_addr RESET_PC, o_inst_valid 0, o_inst 0, o_inst_pc 0, o_misalign 0. Queue empty; fetch_pc = RESET_PC; state RUN.
- States: RUN normal fetch; FLUSH waiting to discard a stale in-flight request; HALT (macro only) stopped after a misaligned redirect.
- Memory bus: at most one outstanding request. Once o_mem_req rises, it and o_mem_addr are held until the i_mem_ack cycle. Memory may ack in the request cycle (zero wait) or later.
- Issue rule (RUN): a new request starts only when count + outstanding < DEPTH, so an ack always has queue space.
- On ack in RUN: push {fetch_pc, i_mem_rdata}; fetch_pc += 4, wrapping 32'hFFFF_FFFC to 0.
- Pop: when o_inst_valid && i_inst_ready. Push and pop in the same cycle are allowed; count is unchanged.
- Redirect (priority over push, pop and issue):
  - Queue is emptied; fetch_pc = i_redirect_pc.
  - If a request is outstanding and not acked this cycle: enter FLUSH. Keep the request with its old address until ack, discard the data, then return to RUN.
  - If the ack coincides with the redirect: discard the data and stay in RUN.
  - A pop in the redirect cycle is absorbed by the flush; decode squashes it.
- Redirect while in FLUSH: the latest target wins; stay in FLUSH.

## Timing
- First o_mem_req in the first cycle after reset is released, at address RESET_PC.
- Ack to o_inst_valid: 1 cycle, through the registered queue.
- Zero-wait memory with decode always ready: 1 instruction per cycle sustained.
- Redirect to the first request at the target:
  - next cycle if nothing is outstanding or the ack coincided;
  - otherwise the cycle after the stale ack.
- Target instruction reaches decode at earliest 2 cycles after the redirect.
- Reset in the middle of a transaction drops the request immediately; the memory must tolerate an abandoned request.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - A redirect with i_redirect_pc[1:0] != 0 sets o_misalign (registered, sticky) and enters HALT after any stale ack.
  - No requests are issued in HALT; the queue stays empty.
  - A later aligned redirect clears o_misalign and resumes fetch; a misaligned one keeps HALT.
- FETCH_ALIGN_CHECK_EN undefined: i_redirect_pc[1:0] is forced to 0, there is no o_misalign port, and there is no HALT state.

## Structure
- Shared package fetch_pkg holds: INST_BYTES = 4, NOP_INST = 32'h0000_0013, entry struct {pc[31:0], inst[31:0]}, and the state enum {RUN, FLUSH, HALT}.
- One sub-module, fetch_queue: a synchronous FIFO of fetch_pkg entries with push, pop, flush, count, and registered head outputs. Flush takes priority over push.

## Test plan
- Reset release, zero-wait memory returning addr^32'hA5A5_A5A5, i_inst_ready=1 -> o_mem_addr 0,4,8,…; o_inst_pc 0,4,8 on consecutive cycles starting 1 cycle after the first ack.
- i_inst_ready=0, DEPTH=4, zero-wait memory -> exactly 4 acks then o_mem_req stays 0; raising i_inst_ready resumes fetch within 1 cycle and PCs stay in order.
- 3-cycle ack latency; i_redirect to 32'h100 one cycle after a request to 32'h8 -> that request is held to its ack, data dropped, next o_mem_addr 32'h100, and no PC-0x8 word ever reaches decode.
- i_redirect to 32'h40 in the same cycle as an ack -> data dropped; request at 32'h40 the next cycle.
- Redirect to 32'hFFFF_FFFC -> following fetch address 32'h0000_0000.
- With FETCH_ALIGN_CHECK_EN, redirect to 32'h102 -> o_misalign=1 and no requests; then redirect to 32'h200 -> o_misalign=0 and fetch resumes at 32'h200.
